// File: rtl/act_pkg.sv
// act_pkg: shared types and widths for the activation arbiter slice.
//   act_type_e  - activation function selector understood by activation_unit
//   arb_state_e - sequencing states of activation_arbiter
//   ACT_IN_W    - signed operand width fed to the unit
//   ACT_OUT_W   - result width returned by the unit
package act_pkg;

  localparam int ACT_IN_W  = 16;
  localparam int ACT_OUT_W = 8;

  typedef enum logic [1:0] {
    RELU    = 2'b00,
    TANH    = 2'b01,
    SIGMOID = 2'b10,
    NONE    = 2'b11
  } act_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   i_req   - request vector
//   i_last  - index of the most recently granted requester
//   o_grant - one-hot grant (zero when nothing is requested)
//   o_idx   - index of the granted requester
//   o_any   - at least one request present
// The search starts one past i_last and wraps, so the last winner has the
// lowest priority. The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = 0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(i_last) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      w_cand = IDX_W'(cand);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/activation_arbiter.sv
// activation_arbiter: shares one activation_unit among NUM_REQ requesters.
//   clk, rst_n                 - clock, synchronous active-low reset
//   req_valid/req_ready        - per-requester request handshake (ready one-hot)
//   req_data, req_act_type     - packed operands (16b signed) and types (2b)
//   rsp_valid/rsp_ready        - per-requester response handshake (valid one-hot)
//   rsp_data                   - shared 8b result bus, zero when no response
//   act_type/act_enable/act_data_in  - drive to activation_unit
//   act_data_out/act_valid     - result from activation_unit
//   busy                       - an operation is in flight
//   err_timeout/err_clr        - sticky watchdog flag and its clear
//   op_count                   - completed responses, wraps
// One operation in flight at a time: IDLE grant -> ISSUE pulse -> WAIT for
// valid (watchdog bounded) -> RESP until the owner accepts.
module activation_arbiter
  import act_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ACT_IN_W*NUM_REQ-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]          req_act_type,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [ACT_OUT_W-1:0]          rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [1:0]                    act_type,
  output logic                          act_enable,
  output logic [ACT_IN_W-1:0]           act_data_in,
  input  logic [ACT_OUT_W-1:0]          act_data_out,
  input  logic                          act_valid,
  output logic                          busy,
  output logic                          err_timeout,
  input  logic                          err_clr,
  output logic [CNT_W-1:0]              op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

  arb_state_e            r_state;
  logic [IDX_W-1:0]      r_last;
  logic [IDX_W-1:0]      r_owner;
  logic [ACT_IN_W-1:0]   r_data;
  act_type_e             r_type;
  logic [ACT_OUT_W-1:0]  r_rsp;
  logic [WD_W-1:0]       r_wd;
  logic                  r_err;
  logic [CNT_W-1:0]      r_count;

  logic [ACT_IN_W-1:0]   w_req_data [NUM_REQ];
  logic [1:0]            w_req_type [NUM_REQ];
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_idle;
  logic                  w_resp;
  logic                  w_timeout;

  // Unpack the flat request buses so the winner can be selected by index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = req_data[ACT_IN_W*gi +: ACT_IN_W];
      assign w_req_type[gi] = req_act_type[2*gi +: 2];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_idle = (r_state == IDLE);
  assign w_resp = (r_state == RESP);
  // Expiry only when the unit is silent in the final counted WAIT cycle;
  // a valid arriving in that same cycle still wins.
  assign w_timeout = (r_state == WAIT) && !act_valid &&
                     (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  // The picked winner is always valid, so ready implies the handshake.
  assign req_ready   = w_idle ? w_grant : '0;
  assign act_enable  = (r_state == ISSUE);
  assign act_data_in = r_data;
  assign act_type    = r_type;
  assign rsp_valid   = w_resp ? (NUM_REQ'(1) << r_owner) : '0;
  assign rsp_data    = w_resp ? r_rsp : '0;
  assign busy        = !w_idle;
  assign err_timeout = r_err;
  assign op_count    = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_data  <= '0;
      r_type  <= RELU;
      r_rsp   <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_data  <= w_req_data[w_idx];
            r_type  <= act_type_e'(w_req_type[w_idx]);
            r_owner <= w_idx;
            r_last  <= w_idx;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (act_valid) begin
            r_rsp   <= act_data_out;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_rsp   <= '0;
            r_state <= RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        RESP: begin
          // Only the owner's accept counts; other rsp_ready bits are ignored.
          if (rsp_ready[r_owner]) begin
            r_count <= r_count + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A same-cycle expiry beats the clear.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_activation_arbiter.sv
// tb_activation_arbiter: directed + randomized checks of activation_arbiter
// against a transaction-level reference model. A behavioural activation unit
// stub answers act_enable after a chosen latency (or never).
module tb_activation_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_data = '0;
  logic [2*N-1:0]  req_act_type = '0;
  logic [N-1:0]    rsp_valid;
  logic [7:0]      rsp_data;
  logic [N-1:0]    rsp_ready = '0;
  logic [1:0]      act_type;
  logic            act_enable;
  logic [15:0]     act_data_in;
  logic [7:0]      act_data_out = '0;
  logic            act_valid = 1'b0;
  logic            busy;
  logic            err_timeout;
  logic            err_clr = 1'b0;
  logic [15:0]     op_count;

  always #5 clk = ~clk;

  activation_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_act_type (req_act_type),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .act_type     (act_type),
    .act_enable   (act_enable),
    .act_data_in  (act_data_in),
    .act_data_out (act_data_out),
    .act_valid    (act_valid),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_clr      (err_clr),
    .op_count     (op_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  t;
  } req_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Pending requests per requester; the head is what the requester presents.
  req_t q [N][$];

  // Reference model state (transaction level).
  bit          m_idle = 1'b1;
  int          m_last = N - 1;
  logic [15:0] m_cnt  = '0;
  bit          m_err  = 1'b0;
  // In-flight operation.
  int          f_idx = 0, f_en = 0, f_lat = 0, f_bp = 0, f_rw = 0, f_rsp_cyc = 0;
  logic [15:0] f_data = '0;
  logic [1:0]  f_type = '0;
  bit          f_never = 1'b0;
  // Stimulus knobs: lat_mode 0 = unit never answers, <0 random 1..6.
  int          lat_mode = 3;
  int          bp_mode  = 0;
  bit          clr_req  = 1'b0;
  // Activation unit stub.
  bit          u_busy = 1'b0;
  int          u_cnt = 0;
  int          u_lat_next = 1;
  logic [15:0] u_data = '0;
  logic [1:0]  u_type = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Behavioural activation: input scaled by 1/16 then shaped and saturated.
  function automatic logic [7:0] unit_fn(input logic [15:0] x, input logic [1:0] t);
    int v;
    v = int'($signed(x)) >>> 4;
    case (t)
      2'b00:   if (v < 0) v = 0;
      2'b10:   v = v / 2 + 64;
      default: ;
    endcase
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  function automatic int pick(input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (q[j].size() > 0) return j;
    end
    return -1;
  endfunction

  function automatic bit pending();
    bit p;
    p = !m_idle;
    for (int i = 0; i < N; i++) if (q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push(input int i, input logic [15:0] d, input logic [1:0] t);
    req_t r;
    r.d = d;
    r.t = t;
    q[i].push_back(r);
  endtask

  task automatic unit_step();
    if (act_enable === 1'b1) begin
      u_busy = 1'b1;
      u_cnt  = u_lat_next;
      u_data = act_data_in;
      u_type = act_type;
      act_valid    = 1'b0;
      act_data_out = 8'($urandom);
    end else if (u_busy && u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        act_valid    = 1'b1;
        act_data_out = unit_fn(u_data, u_type);
        u_busy       = 1'b0;
      end else begin
        act_valid    = 1'b0;
        act_data_out = 8'($urandom);
      end
    end else begin
      // Stray valids whenever the arbiter is not waiting on the unit.
      act_valid    = !u_busy && ($urandom_range(0, 3) == 0);
      act_data_out = 8'($urandom);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[16*i +: 16]  = q[i][0].d;
        req_act_type[2*i +: 2] = q[i][0].t;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[16*i +: 16]  = 16'($urandom);
        req_act_type[2*i +: 2] = 2'($urandom);
      end
      rsp_ready[i] = 1'($urandom);
    end
    if (!m_idle) begin
      if (cyc >= f_rsp_cyc) f_rw++;
      rsp_ready[f_idx] = (f_rw > f_bp);
    end
    err_clr = clr_req;
    clr_req = 1'b0;
  endtask

  task automatic cycle();
    int          g;
    bit          in_op;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [7:0]  exp_rd;
    @(posedge clk);
    #1;
    cyc++;
    unit_step();
    drive();
    #1;
    in_op = !m_idle;
    g = m_idle ? pick(m_last) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (in_op && f_never && cyc == f_rsp_cyc) m_err = 1'b1;
    chk("act_enable", 32'(act_enable), 32'(in_op && cyc == f_en));
    if (in_op && cyc >= f_en && cyc < f_rsp_cyc) begin
      chk("act_data_in", 32'(act_data_in), 32'(f_data));
      chk("act_type", 32'(act_type), 32'(f_type));
    end
    exp_rv = '0;
    exp_rd = '0;
    if (in_op && cyc >= f_rsp_cyc) begin
      exp_rv[f_idx] = 1'b1;
      exp_rd = f_never ? 8'h00 : unit_fn(f_data, f_type);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_data", 32'(rsp_data), 32'(exp_rd));
    chk("busy", 32'(busy), 32'(in_op));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));

    // Advance the model across the coming edge.
    if (err_clr && !(in_op && f_never && cyc == f_rsp_cyc - 1)) m_err = 1'b0;
    if (in_op && f_never && cyc == f_rsp_cyc) u_busy = 1'b0;
    if (g >= 0) begin
      f_idx   = g;
      f_data  = q[g][0].d;
      f_type  = q[g][0].t;
      void'(q[g].pop_front());
      f_en    = cyc + 1;
      f_lat   = (lat_mode < 0) ? int'($urandom_range(1, 6)) : lat_mode;
      f_never = (f_lat == 0);
      u_lat_next = f_lat;
      f_rsp_cyc = f_never ? f_en + TO + 1 : f_en + 1 + f_lat;
      f_bp    = (bp_mode < 0) ? int'($urandom_range(0, 3)) : bp_mode;
      f_rw    = 0;
      m_idle  = 1'b0;
      m_last  = g;
    end else if (in_op && cyc >= f_rsp_cyc && rsp_ready[f_idx]) begin
      m_cnt++;
      m_idle = 1'b1;
      $display("op %0d: req=%0d type=%0d data=%h rsp=%h cycle=%0d",
               m_cnt, f_idx, f_type, f_data, exp_rd, cyc);
    end
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    cyc++;
    unit_step();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n  = 1'b1;
    m_idle = 1'b1;
    m_last = N - 1;
    m_cnt  = '0;
    m_err  = 1'b0;
    unit_step();
    req_valid = '0;
    rsp_ready = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_act_enable", 32'(act_enable), 32'(0));
    chk("rst_act_data_in", 32'(act_data_in), 32'(0));
    chk("rst_act_type", 32'(act_type), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err_timeout), 32'(0));
    chk("rst_op_count", 32'(op_count), 32'(0));
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_budget", 32'(pending()), 32'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    reset_cycle();

    // Single request: requester 2, RELU 0x0100.
    lat_mode = 3; bp_mode = 0;
    push(2, 16'h0100, 2'b00);
    run_drain(50);

    // All four at once, NONE, from a fresh pointer: grants 0,1,2,3.
    reset_cycle();
    for (int i = 0; i < N; i++) push(i, 16'((i + 1) * 256), 2'b11);
    run_drain(200);

    // Response backpressure with another requester pending.
    bp_mode = 10;
    push(0, 16'h0300, 2'b11);
    push(1, 16'h0500, 2'b00);
    run_drain(200);
    bp_mode = 0;

    // Watchdog expiry, then clear, then a good op.
    lat_mode = 0;
    push(1, 16'h1234, 2'b01);
    run_drain(200);
    clr_req = 1'b1;
    cycle();
    cycle();
    lat_mode = 2;
    push(0, 16'h0040, 2'b01);
    run_drain(50);

    // Expiry with err_clr in the same cycle: the set wins.
    lat_mode = 0;
    push(2, 16'h0777, 2'b10);
    cycle();
    cycle();
    for (int n = 0; n < 150 && !m_idle && cyc < f_rsp_cyc - 2; n++) cycle();
    clr_req = 1'b1;
    cycle();
    run_drain(50);
    clr_req = 1'b1;
    cycle();

    // Reset in the middle of WAIT; the unit answers late into IDLE.
    lat_mode = 20;
    push(3, 16'h0200, 2'b00);
    cycle();
    for (int n = 0; n < 40 && !(!m_idle && cyc >= f_en + 5); n++) cycle();
    reset_cycle();
    repeat (25) cycle();
    lat_mode = 2;
    push(1, 16'h0250, 2'b11);
    run_drain(50);

    // Negative operands and fairness around a busy requester 1.
    lat_mode = -1; bp_mode = -1;
    push(1, 16'hFFC0, 2'b01);
    cycle();
    cycle();
    push(0, 16'hFF00, 2'b00);
    push(2, 16'h0123, 2'b10);
    run_drain(200);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int nreq;
      nreq = int'($urandom_range(0, 2));
      for (int k = 0; k < nreq; k++)
        push(int'($urandom_range(0, N - 1)), 16'($urandom), 2'($urandom));
      if ($urandom_range(0, 9) == 0) clr_req = 1'b1;
      repeat ($urandom_range(1, 8)) cycle();
    end
    run_drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/activation_arbiter.md
Name: activation_arbiter

Overview:
Shares one activation_unit among NUM_REQ requesters, such as PE-array output columns. Each requester supplies a 16-bit signed accumulator value and a 2-bit activation type.
The arbiter grants requesters round-robin and sequences the unit: it drives the operands, pulses enable, waits for valid, and returns the 8-bit result to the granted requester.
Exactly one operation is in flight at a time. A watchdog protects against a unit that never asserts valid.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 64, cycles in WAIT with no act_valid before a timeout response is forced
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_data  in  16*NUM_REQ  packed signed operands, requester i at [16i+15:16i]
req_act_type  in  2*NUM_REQ  packed activation type per requester
rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
rsp_data  out  8  activation result, shared bus
rsp_ready  in  NUM_REQ  per-requester response accept
act_type  out  2  to activation_unit activation_type
act_enable  out  1  to activation_unit enable, one-cycle pulse
act_data_in  out  16  to activation_unit data_in (signed)
act_data_out  in  8  from activation_unit data_out
act_valid  in  1  from activation_unit valid
busy  out  1  state != IDLE
err_timeout  out  1  sticky flag, set on watchdog expiry
err_clr  in  1  clears err_timeout
op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, all outputs 0, rr pointer last=NUM_REQ-1 (requester 0 wins first), op_count=0, err_timeout=0.
- Reset in any state drops the in-flight operation without a response; act_enable is 0 in the cycle after reset.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g is the first i with req_valid[i], searching from last+1 and wrapping at NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - On the handshake edge: capture req_data[g] and req_act_type[g], set owner=g and last=g, go to ISSUE.
  - With no valid requests, stay in IDLE with the pointer unchanged.
- ISSUE (1 cycle):
  - act_enable=1; act_data_in and act_type show the captured values.
  - Go to WAIT; clear the watchdog counter.
- WAIT:
  - act_data_in and act_type stay stable; act_enable=0.
  - act_valid=1: capture act_data_out into the response register, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no act_valid: response register=0x00, set err_timeout, go to RESP.
  - act_valid outside WAIT is ignored, including a level-held valid from the previous operation.
- RESP:
  - rsp_valid[owner]=1; rsp_data holds the response register.
  - rsp_ready on any requester other than owner is ignored.
  - On rsp_ready[owner]: op_count+1, go to IDLE. A new grant occurs no earlier than the following IDLE cycle.
- err_clr has priority below a same-cycle set: err_timeout set and cleared in the same cycle ends up 1.
- rsp_data=0 whenever rsp_valid is 0.
- Latency: handshake edge at T, act_enable high in cycle T+1, rsp_valid high no earlier than T+3. Sustained throughput is at most 1 op per (unit latency + 3) cycles.
- Fairness: with all requesters continuously valid, the grant order is 0,1,..,NUM_REQ-1,0,...
- Requests held during busy stay pending; requesters must hold valid, data and type stable until req_ready.

Decomposition:
- act_pkg:
  - act_type_e: RELU=2'b00, TANH=2'b01, SIGMOID=2'b10, NONE=2'b11.
  - arb_state_e: IDLE, ISSUE, WAIT, RESP.
  - Widths ACT_IN_W=16 and ACT_OUT_W=8.
- Sub-module rr_arbiter: combinational round-robin picker from req vector and last pointer to one-hot grant plus index; pointer register stays in activation_arbiter.

Test Plan:
- Single request: requester 2 with type RELU, data 0x0100 -> act_enable pulse of one cycle, rsp_valid=4'b0100, rsp_data=0x10 (±2), op_count=1.
- All four requesters valid at once with NONE and data 0x0100,0x0200,0x0300,0x0400 -> grants in order 0,1,2,3; responses 0x10,0x20,0x30,0x40; each requester sees only its own rsp_valid.
- Response backpressure: hold rsp_ready low for 10 cycles while requester 1 waits -> rsp_valid and rsp_data stable, no new grant, busy=1; after release, requester 1 is granted next.
- Timeout: stub unit never asserts valid -> after 64 WAIT cycles rsp_data=0x00 and err_timeout=1; err_clr pulse -> 0; next op (TANH, 0x0040) returns 0x04.
- Reset asserted mid-WAIT -> next cycle all outputs 0 and state IDLE; a late act_valid is ignored; the next request gets a correct response.
- Negative input: ReLU with -0x0100 -> 0x00; TANH with -0x0040 -> 0xFC; requests 0,2 with 1 busy -> pointer fairness holds.
